// File: rtl/filter_out_capture.sv
// Capture RAM at the FIR output: drops SKIP_N pipeline-fill samples, stores the next
// 2**ADDR_W valid outputs, registered readback. Optional |x| peak tracker: CAPTURE_PEAK_EN.
module filter_out_capture #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SKIP_N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
`ifdef CAPTURE_PEAK_EN
  output logic [DATA_W-1:0]        peak_abs,
`endif
  output logic [ADDR_W:0]          count
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned SkipW = (SKIP_N > 1) ? $clog2(SKIP_N + 1) : 1;
  localparam logic [SkipW-1:0] SkipLast = SkipW'((SKIP_N > 0) ? SKIP_N - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSkip, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic [SkipW-1:0]    skip_q, skip_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [Depth];

`ifdef CAPTURE_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_d, abs_in;

  // The most negative code has no positive twin, so it saturates.
  always_comb begin
    abs_in = in_data;
    if (in_data[DATA_W-1]) begin
      if (in_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
        abs_in = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        abs_in = DATA_W'(-in_data);
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
`ifdef CAPTURE_PEAK_EN
    peak_d   = peak_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = (SKIP_N > 0) ? StSkip : StCapture;
          skip_d   = '0;
          wr_ptr_d = '0;
          count_d  = '0;
`ifdef CAPTURE_PEAK_EN
          peak_d   = '0;
`endif
        end
      end
      StSkip: begin
        if (in_valid) begin
          skip_d = skip_q + 1'b1;
          if (skip_q == SkipLast) state_d = StCapture;
        end
      end
      StCapture: begin
        if (in_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (wr_ptr_q == '1) state_d = StDone;
`ifdef CAPTURE_PEAK_EN
          if (abs_in > peak_q) peak_d = abs_in;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      skip_q    <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
`ifdef CAPTURE_PEAK_EN
      peak_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rd_data_q <= mem_q[rd_addr];
`ifdef CAPTURE_PEAK_EN
      peak_q    <= peak_d;
`endif
    end
  end

  // RAM is never reset; read-before-write falls out of the non-blocking update.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= in_data;
  end

  assign rd_data = rd_data_q;
  assign busy    = (state_q == StSkip) || (state_q == StCapture);
  assign done    = (state_q == StDone);
  assign count   = count_q;
`ifdef CAPTURE_PEAK_EN
  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_filter_out_capture.sv
// Directed bench for filter_out_capture: reset, skip/capture, gaps, ignore rules, re-arm.
module tb_filter_out_capture;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0]        rd_addr = '0;
  logic signed [DATA_W-1:0] rd_data;
  logic                     busy, done;
  logic [ADDR_W:0]          count;
`ifdef CAPTURE_PEAK_EN
  logic [DATA_W-1:0]        peak_abs;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int vals [4] = '{511, -75, 256, -436};

  filter_out_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SKIP_N(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
`ifdef CAPTURE_PEAK_EN
    .peak_abs (peak_abs),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given valid/data; outputs are sampled 1ns after the edge.
  task automatic beat(input logic v, input int d);
    in_valid = v;
    in_data  = d[DATA_W-1:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic v, input int d);
    start = 1'b1;
    beat(v, d);
    start = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int addr, input int exp);
    rd_addr = addr[ADDR_W-1:0];
    beat(1'b0, 0);
    check_eq(tag, $signed(rd_data), exp);
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_rd", $signed(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-capture: 12 valid beats leave 4 words written
    pulse_start(1'b0, 0);
    for (int i = 0; i < 12; i++) beat(1'b1, i);
    check_eq("mid_count", count, 4);
    check_eq("mid_busy", busy, 1);
    check_eq("mid_rd0", $signed(rd_data), 8);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_count", count, 0);
    check_eq("arst_rd", $signed(rd_data), 0);
    check_eq("arst_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic capture 0..39
    pulse_start(1'b0, 0);
    check_eq("basic_busy0", busy, 1);
    for (int i = 0; i < 40; i++) begin
      beat(1'b1, i);
      if (i == 7) check_eq("skip_end_cnt", count, 0);
      if (i == 8) check_eq("first_cap_cnt", count, 1);
      if (i == 38) check_eq("pre_done", done, 0);
    end
    check_eq("basic_done", done, 1);
    check_eq("basic_busy", busy, 0);
    check_eq("basic_count", count, 32);
    read_chk("basic_rd5", 5, 13);
    read_chk("basic_rd0", 0, 8);
    read_chk("basic_rd31", 31, 39);

    // in_valid in DONE is ignored
    for (int i = 0; i < 3; i++) beat(1'b1, 999);
    check_eq("done_cnt_hold", count, 32);
    check_eq("done_hold", done, 1);
    read_chk("done_ram_0", 0, 8);
    read_chk("done_ram_31", 31, 39);

    // Gapped signed stream, with a start pulse mid-capture at count=10
    pulse_start(1'b0, 0);
    for (int k = 0; k < 40; k++) begin
      beat(1'b1, vals[k % 4]);
      if (k == 17) begin
        check_eq("gap_cnt10", count, 10);
        pulse_start(1'b0, 0);
        check_eq("ign_start_cnt", count, 10);
        check_eq("ign_start_busy", busy, 1);
      end else if (k < 39) begin
        beat(1'b0, 12345);
      end
      if (k == 20) check_eq("gap_stall_cnt", count, 13);
      if (k == 38) check_eq("gap_pre_done", done, 0);
    end
    check_eq("gap_done", done, 1);
    check_eq("gap_count", count, 32);
    read_chk("gap_rd1", 1, -75);
    read_chk("gap_rd0", 0, 511);
    read_chk("gap_rd3", 3, -436);
    read_chk("gap_rd31", 31, -436);
`ifdef CAPTURE_PEAK_EN
    check_eq("gap_peak", peak_abs, 511);
`endif

    // Re-arm from DONE; the same-cycle valid sample is not counted
    pulse_start(1'b1, 777);
    check_eq("rearm_cnt", count, 0);
    check_eq("rearm_busy", busy, 1);
    rd_addr = 3;
    for (int i = 0; i < 40; i++) begin
      beat(1'b1, (i == 20) ? -524288 : 100 + i);
      if (i == 7) check_eq("rearm_skip_cnt", count, 0);
      if (i == 11) check_eq("rbw_old", $signed(rd_data), -436);
      if (i == 12) check_eq("rbw_new", $signed(rd_data), 111);
    end
    check_eq("rearm_done", done, 1);
    check_eq("rearm_count", count, 32);
    read_chk("rearm_rd0", 0, 108);
    read_chk("rearm_rd12", 12, -524288);
    read_chk("rearm_rd31", 31, 139);
`ifdef CAPTURE_PEAK_EN
    check_eq("rearm_peak", peak_abs, 524287);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/filter_out_capture.md
Name: filter_out_capture

Overview:
- Sample sink at the output end of the systolic FIR datapath; the counterpart of the input sample ROM.
- After a start pulse, it discards a fixed number of pipeline-fill samples, then writes the next DEPTH valid filter outputs into an internal RAM.
- Captured results are read back through a registered read port by the testbench or a later readout block.

Parameters:
- DATA_W, 20, width of the signed filter output sample.
- ADDR_W, 5, capture RAM address width; DEPTH = 2**ADDR_W (32, one full input-ROM period).
- SKIP_N, 8, number of valid samples discarded after start (pipeline fill); 0 allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle arm pulse; honoured only in IDLE or DONE.
- in_valid  in  1  in_data is a new filter output this cycle.
- in_data  in  DATA_W  signed filter output sample.
- rd_addr  in  ADDR_W  readback address.
- rd_data  out  DATA_W  signed RAM word at rd_addr, registered.
- busy  out  1  high in SKIP or CAPTURE.
- done  out  1  high in DONE.
- count  out  ADDR_W+1  number of samples written in the current capture.

Behaviour:
- Reset (async, rst=1):
  - state <= IDLE; rd_data, count, internal skip counter, write pointer <= 0.
  - busy=0, done=0.
  - RAM contents are not cleared.
- States: IDLE, SKIP, CAPTURE, DONE. busy and done decode combinationally from the state register.
- IDLE:
  - start=1 goes to SKIP if SKIP_N>0, else to CAPTURE.
  - On the same edge, skip counter, write pointer and count clear.
- SKIP:
  - Each in_valid=1 cycle increments the skip counter; data is discarded.
  - When the SKIP_N-th valid sample is consumed, go to CAPTURE on that edge.
  - That sample is not stored.
- CAPTURE:
  - Each in_valid=1 cycle: mem[wr_ptr] <= in_data; wr_ptr++; count++.
  - On the edge that performs the DEPTH-th write, go to DONE; count = DEPTH (32).
  - in_valid=0 cycles stall with no change.
- DONE:
  - done held high and the RAM frozen; in_valid ignored.
  - start=1 re-arms exactly as from IDLE, and count clears.
- start while busy is ignored; there is no restart mid-capture.
- in_valid in IDLE or DONE is ignored; there are no writes.
- start and in_valid in the same IDLE/DONE cycle: the sample is not counted or stored. Counting begins the following cycle.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, giving 1-cycle latency, in all states.
  - A read of the address being written in the same cycle returns the old word (read-before-write).
- Write pointer width is ADDR_W and wraps naturally. DONE is entered before any wrap, so no location is overwritten within one capture.
- in_data is stored verbatim (two's complement); there is no truncation or rounding.

Optional Feature:
- Macro: CAPTURE_PEAK_EN.
- When defined:
  - Extra output peak_abs [DATA_W-1:0] (unsigned) tracks the max |in_data| over samples written in CAPTURE.
  - It clears to 0 on reset and on an accepted start.
  - |-2**(DATA_W-1)| saturates to 2**(DATA_W-1)-1.
  - Valid (final) once done=1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-capture: start, 12 valid samples, assert rst asynchronously between edges -> busy/done/count/rd_data drop to 0 immediately. A new start then skips 8 samples afresh.
- Basic capture: SKIP_N=8, start, stream values 0..39 with in_valid=1 -> samples 0..7 dropped, mem[0..31]=8..39. done rises on the edge of the 40th sample; count=32; reading rd_addr=5 gives 13 one cycle later.
- Gapped valid: in_valid toggled 1,0,1,0 with signed values 511, -75, 256, -436 repeating -> only valid beats counted. done after 8+32 valid beats; mem[1]=-75 sign-correct.
- Ignore rules: start pulse while in CAPTURE at count=10 -> no effect, capture completes normally. in_valid with data 999 in DONE -> RAM unchanged.
- Re-arm from DONE: start, stream 100..139 -> count restarts at 0, mem[0]=108, done re-asserts after 40 beats. Read-during-write of mem[3] returns the previous capture's value.
- CAPTURE_PEAK_EN: captured data includes -436 and 511 and minimum -524288 -> peak_abs=524287 at done. Without the macro, the build elaborates with no peak_abs port.
